// File: rtl/game_frame_renderer_if.sv
// Pixel stream bus between the game logic controller, the frame renderer and the
// video output stage. The slave modport is the renderer's view of the bus.
interface game_frame_renderer_if;
   localparam int unsigned HW   = 11;
   localparam int unsigned VW   = 10;
   localparam int unsigned DW   = 8;
   localparam int unsigned GSW  = 3;
   localparam int unsigned RGBW = 24;
   localparam int unsigned CW   = 16;
   localparam int unsigned MW   = 2;

   // annotated pixel stream from the game logic controller
   logic [HW-1:0]   hcount_in;
   logic [VW-1:0]   vcount_in;
   logic            data_valid_in;
   logic [DW-1:0]   wall_depth_in;
   logic            is_wall_in;
   logic            is_person_in;
   logic            is_collision_in;
   logic [GSW-1:0]  game_state_in;

   // rendered stream and frame statistics towards the output stage
   logic [HW-1:0]   hcount_out;
   logic [VW-1:0]   vcount_out;
   logic            data_valid_out;
   logic [RGBW-1:0] pixel_out;
   logic [CW-1:0]   collision_count_out;
   logic            frame_done_out;
   logic [MW-1:0]   mode_out;

   modport master (
      output hcount_in, vcount_in, data_valid_in, wall_depth_in,
             is_wall_in, is_person_in, is_collision_in, game_state_in,
      input  hcount_out, vcount_out, data_valid_out, pixel_out,
             collision_count_out, frame_done_out, mode_out
   );

   modport slave (
      input  hcount_in, vcount_in, data_valid_in, wall_depth_in,
             is_wall_in, is_person_in, is_collision_in, game_state_in,
      output hcount_out, vcount_out, data_valid_out, pixel_out,
             collision_count_out, frame_done_out, mode_out
   );
endinterface

// File: rtl/game_frame_renderer.sv
// Game frame renderer: colours the annotated pixel stream, counts collision
// pixels per frame and sequences the hit-flash / game-over display modes.
module game_frame_renderer #(
   parameter int unsigned SCREEN_WIDTH     = 1280,
   parameter int unsigned SCREEN_HEIGHT    = 720,
   parameter int unsigned GOAL_DEPTH       = 60,
   parameter int unsigned GOAL_DEPTH_DELTA = 10,
   parameter int unsigned FLASH_FRAMES     = 8,
   parameter logic [23:0] BG_COLOR         = 24'h202020
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   game_frame_renderer_if.slave  px
);

   localparam int unsigned HW      = 11;
   localparam int unsigned VW      = 10;
   localparam int unsigned DW      = 8;
   localparam int unsigned PW      = 10;
   localparam int unsigned RGBW    = 24;
   localparam int unsigned CW      = 16;
   localparam int unsigned FLASH_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

   localparam logic [HW-1:0]      LAST_H     = HW'(SCREEN_WIDTH - 1);
   localparam logic [VW-1:0]      LAST_V     = VW'(SCREEN_HEIGHT - 1);
   localparam logic [DW-1:0]      DEPTH_LO   = DW'(GOAL_DEPTH - GOAL_DEPTH_DELTA);
   localparam logic [DW-1:0]      DEPTH_HI   = DW'(GOAL_DEPTH + GOAL_DEPTH_DELTA);
   localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_FRAMES - 1);
   localparam logic [RGBW-1:0]    RED        = 24'hFF0000;
   localparam logic [RGBW-1:0]    GREEN      = 24'h00FF00;
   localparam logic [RGBW-1:0]    YELLOW     = 24'hFFFF00;
   localparam logic [CW-1:0]      CNT_MAX    = 16'hFFFF;

   typedef enum logic [1:0] {
      MODE_PLAYING   = 2'd0,
      MODE_FLASH     = 2'd1,
      MODE_GAME_OVER = 2'd2
   } mode_e;

   // display state
   mode_e               mode_q, mode_d;
   logic [FLASH_W-1:0]  flash_cnt_q, flash_cnt_d;

   // stage 1
   logic                s1_valid_q;
   logic [HW-1:0]       s1_h_q;
   logic [VW-1:0]       s1_v_q;
   logic [RGBW-1:0]     s1_base_q, s1_base_d;
   mode_e               s1_mode_q;
   logic                s1_flash_b0_q;
   logic                s1_coll_q;

   // stage 2 / outputs
   logic                out_valid_q;
   logic [HW-1:0]       out_h_q;
   logic [VW-1:0]       out_v_q;
   logic [RGBW-1:0]     out_pix_q, out_pix_d;

   // collision statistics
   logic [CW-1:0]       coll_cnt_q, coll_cnt_d;
   logic [CW-1:0]       coll_total_q, coll_total_d;
   logic                frame_done_q;

   logic                fe_c;
   logic                lost_c;
   logic                coll_hit_c;
   logic [CW-1:0]       coll_sum_c;
   logic [PW-1:0]       depth_x3_c;
   logic [DW-1:0]       depth_blue_c;
   logic                in_window_c;

   assign fe_c       = px.data_valid_in && (px.hcount_in == LAST_H) && (px.vcount_in == LAST_V);
   assign lost_c     = (px.game_state_in == 3'd0);
   assign coll_hit_c = px.data_valid_in && px.is_collision_in;

   assign depth_x3_c   = PW'(px.wall_depth_in) * PW'(3);
   assign depth_blue_c = (depth_x3_c > PW'(255)) ? 8'hFF : depth_x3_c[DW-1:0];
   assign in_window_c  = (px.wall_depth_in >= DEPTH_LO) && (px.wall_depth_in <= DEPTH_HI);

   assign coll_sum_c = (coll_hit_c && (coll_cnt_q != CNT_MAX)) ? coll_cnt_q + CW'(1) : coll_cnt_q;

   // Display-mode transitions, evaluated only on the frame-end pixel
   always_comb begin
      mode_d      = mode_q;
      flash_cnt_d = flash_cnt_q;
      if (fe_c) begin
         case (mode_q)
            MODE_PLAYING: begin
               if (lost_c) begin
                  mode_d      = MODE_FLASH;
                  flash_cnt_d = '0;
               end
            end
            MODE_FLASH: begin
               if (!lost_c) begin
                  mode_d = MODE_PLAYING;
               end else if (flash_cnt_q == FLASH_LAST) begin
                  mode_d = MODE_GAME_OVER;
               end else begin
                  flash_cnt_d = flash_cnt_q + FLASH_W'(1);
               end
            end
            MODE_GAME_OVER: begin
               if (!lost_c) mode_d = MODE_PLAYING;
            end
            default: mode_d = MODE_PLAYING;
         endcase
      end
   end

   // Display-mode state register
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         mode_q      <= MODE_PLAYING;
         flash_cnt_q <= '0;
      end else begin
         mode_q      <= mode_d;
         flash_cnt_q <= flash_cnt_d;
      end
   end

   // Base colour by flag priority; invalid pixels are black
   always_comb begin
      s1_base_d = BG_COLOR;
      if (!px.data_valid_in) begin
         s1_base_d = '0;
      end else if (px.is_collision_in) begin
         s1_base_d = RED;
      end else if (px.is_person_in) begin
         s1_base_d = GREEN;
      end else if (px.is_wall_in && in_window_c) begin
         s1_base_d = YELLOW;
      end else if (px.is_wall_in) begin
         s1_base_d = {8'h00, 8'h00, depth_blue_c};
      end
   end

   // Stage 1: capture pixel, base colour and the mode it was sampled under
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s1_valid_q    <= 1'b0;
         s1_h_q        <= '0;
         s1_v_q        <= '0;
         s1_base_q     <= '0;
         s1_mode_q     <= MODE_PLAYING;
         s1_flash_b0_q <= 1'b0;
         s1_coll_q     <= 1'b0;
      end else begin
         s1_valid_q    <= px.data_valid_in;
         s1_h_q        <= px.hcount_in;
         s1_v_q        <= px.vcount_in;
         s1_base_q     <= s1_base_d;
         s1_mode_q     <= mode_q;
         s1_flash_b0_q <= flash_cnt_q[0];
         s1_coll_q     <= px.is_collision_in;
      end
   end

   // Mode overlay: red flash on even flash frames, quarter-brightness when game over
   always_comb begin
      out_pix_d = s1_base_q;
      if (!s1_valid_q) begin
         out_pix_d = '0;
      end else begin
         case (s1_mode_q)
            MODE_FLASH: begin
               if (!s1_flash_b0_q) out_pix_d = RED;
            end
            MODE_GAME_OVER: begin
               if (!s1_coll_q) begin
                  out_pix_d = {2'b00, s1_base_q[23:18],
                               2'b00, s1_base_q[15:10],
                               2'b00, s1_base_q[7:2]};
               end
            end
            default: out_pix_d = s1_base_q;
         endcase
      end
   end

   // Stage 2: output registers, kept aligned with the delayed position/valid
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         out_valid_q <= 1'b0;
         out_h_q     <= '0;
         out_v_q     <= '0;
         out_pix_q   <= '0;
      end else begin
         out_valid_q <= s1_valid_q;
         out_h_q     <= s1_h_q;
         out_v_q     <= s1_v_q;
         out_pix_q   <= out_pix_d;
      end
   end

   // Collision counter: the frame-end pixel belongs to the finishing frame
   always_comb begin
      coll_cnt_d   = coll_sum_c;
      coll_total_d = coll_total_q;
      if (fe_c) begin
         coll_total_d = coll_sum_c;
         coll_cnt_d   = '0;
      end
   end

   // Collision statistics and frame-done pulse registers
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         coll_cnt_q   <= '0;
         coll_total_q <= '0;
         frame_done_q <= 1'b0;
      end else begin
         coll_cnt_q   <= coll_cnt_d;
         coll_total_q <= coll_total_d;
         frame_done_q <= fe_c;
      end
   end

   assign px.hcount_out          = out_h_q;
   assign px.vcount_out          = out_v_q;
   assign px.data_valid_out      = out_valid_q;
   assign px.pixel_out           = out_pix_q;
   assign px.collision_count_out = coll_total_q;
   assign px.frame_done_out      = frame_done_q;
   assign px.mode_out            = mode_q;

endmodule
